// File: rtl/acc_bank_drain.sv
// acc_bank_drain: multi-pass int8 accumulation bank with a channel-major drain
// onto a 32-bit valid/bus_free stream. Optional ReLU is applied on drain.
module acc_bank_drain #(
  parameter int unsigned NCH    = 16,
  parameter int unsigned DEPTH  = 3136,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned PASS_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PASS_W-1:0]  pass_total,
  input  logic               relu_en,
  input  logic               valid_i,
  input  logic [NCH*8-1:0]   data_i,
  output logic               in_ready,
  input  logic               bus_free,
  output logic               valid_o,
  output logic [31:0]        data_o,
  output logic               busy,
  output logic               conv_done
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_CH   = CW'(NCH - 1);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     wr_addr;
  logic [PASS_W-1:0] pass_cnt, pass_tot;
  logic              relu_q;
  logic [CW-1:0]     rd_ch, sel_ch;
  logic [AW-1:0]     rd_addr, sel_addr;
  logic              load;
  logic              accept, xfer, last_addr, last_pass, last_word;
  logic signed [ACC_W-1:0] rd_val;
  logic [31:0]       word;

  logic signed [ACC_W-1:0] acc [NCH][DEPTH];

  // Signed add of one input byte with clamping to the accumulator range.
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [7:0]       b);
    logic signed [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s[SUM_W-1] != s[SUM_W-2]) return s[SUM_W-1] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  assign accept    = valid_i && in_ready;
  assign xfer      = valid_o && bus_free;
  assign last_addr = (wr_addr == LAST_ADDR);
  assign last_pass = (PASS_W'(pass_cnt + 1'b1) == pass_tot);
  assign last_word = (rd_ch == LAST_CH) && (rd_addr == LAST_ADDR);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (accept && last_addr && last_pass) state_d = DRAIN;
      DRAIN:   if (xfer && last_word) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pick the bank entry to present next: entry 0 on drain entry, else the successor.
  always_comb begin
    sel_ch   = rd_ch;
    sel_addr = rd_addr;
    load     = 1'b0;
    if (state_q == ACCUM && state_d == DRAIN) begin
      sel_ch   = '0;
      sel_addr = '0;
      load     = 1'b1;
    end else if (xfer && !last_word) begin
      load = 1'b1;
      if (rd_addr == LAST_ADDR) begin
        sel_addr = '0;
        sel_ch   = CW'(rd_ch + 1'b1);
      end else begin
        sel_addr = AW'(rd_addr + 1'b1);
      end
    end
  end

  // Read the selected entry, apply optional ReLU and sign-extend to the bus width.
  always_comb begin
    rd_val = acc[sel_ch][sel_addr];
    if (relu_q && rd_val[ACC_W-1]) rd_val = '0;
    word = 32'(rd_val);
  end

  // Accumulator bank: pass 0 overwrites, later passes saturate-accumulate.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (pass_cnt == '0) acc[c][wr_addr] <= ACC_W'(signed'(data_i[8*c +: 8]));
        else                acc[c][wr_addr] <= sat_add(acc[c][wr_addr], data_i[8*c +: 8]);
      end
    end
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_addr   <= '0;
      pass_cnt  <= '0;
      pass_tot  <= '0;
      relu_q    <= 1'b0;
      rd_ch     <= '0;
      rd_addr   <= '0;
      in_ready  <= 1'b0;
      valid_o   <= 1'b0;
      busy      <= 1'b0;
      conv_done <= 1'b0;
      data_o    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        wr_addr  <= '0;
        pass_cnt <= '0;
        pass_tot <= (pass_total == '0) ? PASS_W'(1) : pass_total;
        relu_q   <= relu_en;
      end
      if (accept) begin
        wr_addr <= last_addr ? '0 : AW'(wr_addr + 1'b1);
        if (last_addr) pass_cnt <= PASS_W'(pass_cnt + 1'b1);
      end
      if (load) begin
        rd_ch   <= sel_ch;
        rd_addr <= sel_addr;
        data_o  <= word;
      end
      in_ready  <= (state_d == ACCUM);
      valid_o   <= (state_d == DRAIN);
      busy      <= (state_d != IDLE);
      conv_done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_acc_bank_drain.sv
// Directed/randomised bench for acc_bank_drain with a reference model of the bank.
module tb_acc_bank_drain;

  localparam int NCH    = 2;
  localparam int DEPTH  = 4;
  localparam int ACC_W  = 10;
  localparam int PASS_W = 10;
  localparam int TOT    = NCH * DEPTH;
  localparam int AMAX   = (1 << (ACC_W - 1)) - 1;
  localparam int AMIN   = -(1 << (ACC_W - 1));

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [PASS_W-1:0] pass_total;
  logic              relu_en;
  logic              valid_i;
  logic [NCH*8-1:0]  data_i;
  logic              in_ready;
  logic              bus_free;
  logic              valid_o;
  logic [31:0]       data_o;
  logic              busy;
  logic              conv_done;

  int n_chk  = 0;
  int n_fail = 0;

  byte         q0[$];
  byte         q1[$];
  logic [31:0] exp_q[$];

  acc_bank_drain #(.NCH(NCH), .DEPTH(DEPTH), .ACC_W(ACC_W), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pass_total(pass_total), .relu_en(relu_en),
    .valid_i(valid_i), .data_i(data_i), .in_ready(in_ready), .bus_free(bus_free),
    .valid_o(valid_o), .data_o(data_o), .busy(busy), .conv_done(conv_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  // Reference: apply every beat to an integer bank, then list the drain in channel-major order.
  task automatic build_expected(input int passes, input bit relu);
    int m[NCH][DEPTH];
    int v;
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int a = 0; a < DEPTH; a++) begin
        m[0][a] = (p == 0) ? int'(q0[p*DEPTH+a]) : clamp(m[0][a] + int'(q0[p*DEPTH+a]));
        m[1][a] = (p == 0) ? int'(q1[p*DEPTH+a]) : clamp(m[1][a] + int'(q1[p*DEPTH+a]));
      end
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < DEPTH; a++) begin
        v = m[c][a];
        if (relu && v < 0) v = 0;
        exp_q.push_back(32'(v));
      end
  endtask

  task automatic fill_const(input int n, input byte v0, input byte v1);
    q0.delete(); q1.delete();
    for (int i = 0; i < n; i++) begin q0.push_back(v0); q1.push_back(v1); end
  endtask

  task automatic fill_rand(input int n);
    q0.delete(); q1.delete();
    for (int i = 0; i < n; i++) begin
      q0.push_back(byte'($urandom_range(0, 255)));
      q1.push_back(byte'($urandom_range(0, 255)));
    end
  endtask

  // One complete run: start, feed all beats, drain and check every word plus completion.
  task automatic run(input string name, input int ptot, input bit relu, input bit gaps,
                     input int bp, input bit stray);
    int eff, nb, idx, cyc, n, k;
    bit v, rdy, bf, hold;
    logic [31:0] prev;
    eff = (ptot == 0) ? 1 : ptot;
    nb  = eff * DEPTH;
    build_expected(eff, relu);

    @(posedge clk); #1;
    start = 1'b1; pass_total = PASS_W'(ptot); relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0;
    chk({name, "_in_ready_rise"}, in_ready, 1'b1);
    chk({name, "_busy_accum"}, busy, 1'b1);

    idx = 0; cyc = 0;
    while (idx < nb && cyc < 50 * nb + 100) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      valid_i  = v;
      data_i   = {8'(q1[idx]), 8'(q0[idx])};
      bus_free = stray;
      start    = (stray && idx == 2);
      if (start) begin pass_total = PASS_W'(1); relu_en = ~relu; end
      rdy = in_ready;
      @(posedge clk);
      if (v && rdy) idx++;
      cyc++;
      #1;
      start = 1'b0; pass_total = PASS_W'(ptot); relu_en = relu;
    end
    chk({name, "_beats_taken"}, 32'(idx), 32'(nb));
    chk({name, "_in_ready_drop"}, in_ready, 1'b0);
    chk({name, "_valid_o_rise"}, valid_o, 1'b1);

    n = 0; cyc = 0; k = 0;
    while (n < TOT && cyc < 200) begin
      case (bp)
        0:       bf = 1'b1;
        1:       bf = (k % 3 == 0);
        default: bf = $urandom_range(0, 1);
      endcase
      k++;
      bus_free = bf;
      valid_i  = stray;
      data_i   = {8'(-5), 8'(10)};
      hold = valid_o && !bf;
      prev = data_o;
      if (valid_o && bf) begin
        chk($sformatf("%s_word%0d", name, n), data_o, exp_q[n]);
        n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (hold) begin
        chk({name, "_hold_data"}, data_o, prev);
        chk({name, "_hold_valid"}, valid_o, 1'b1);
      end
    end
    chk({name, "_xfer_count"}, 32'(n), 32'(TOT));
    chk({name, "_conv_done_hi"}, conv_done, 1'b1);
    chk({name, "_valid_o_fall"}, valid_o, 1'b0);
    chk({name, "_busy_done"}, busy, 1'b1);
    bus_free = 1'b0; valid_i = 1'b0;
    @(posedge clk); #1;
    chk({name, "_conv_done_lo"}, conv_done, 1'b0);
    chk({name, "_busy_fall"}, busy, 1'b0);
  endtask

  initial begin
    start = 1'b0; pass_total = '0; relu_en = 1'b0; valid_i = 1'b0; data_i = '0; bus_free = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_conv_done", conv_done, 1'b0);
    chk("rst_data_o", data_o, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Single pass, mixed signs.
    q0.delete(); q1.delete();
    for (int i = 0; i < DEPTH; i++) begin q0.push_back(byte'(i + 1)); q1.push_back(byte'(-(i + 1))); end
    run("single", 1, 1'b0, 1'b0, 0, 1'b0);

    // Three passes; a stray beat is driven into the drain.
    fill_const(3 * DEPTH, 8'sd10, -8'sd5);
    run("three", 3, 1'b0, 1'b0, 0, 1'b1);

    // Saturation at both rails with ReLU.
    fill_const(8 * DEPTH, 8'sd127, -8'sd128);
    run("satrelu", 8, 1'b1, 1'b0, 0, 1'b0);

    // Backpressure 1,0,0 pattern.
    fill_rand(2 * DEPTH);
    run("bp", 2, 1'b0, 1'b0, 1, 1'b0);

    // Same random data without and with gaps/stray events.
    fill_rand(3 * DEPTH);
    run("nogap", 3, 1'b0, 1'b0, 0, 1'b0);
    run("gaps", 3, 1'b0, 1'b1, 2, 1'b1);

    // pass_total of zero behaves as one pass.
    fill_rand(DEPTH);
    run("pass0", 0, 1'b1, 1'b0, 2, 1'b0);

    // Long random run with ReLU and saturating extremes.
    fill_rand(6 * DEPTH);
    run("rand", 6, 1'b1, 1'b1, 2, 1'b1);

    // Reset during the second pass, then a fresh single-pass run.
    @(posedge clk); #1;
    start = 1'b1; pass_total = PASS_W'(3); relu_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      valid_i = 1'b1; data_i = {8'(-3), 8'(9)};
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_valid_o", valid_o, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_conv_done", conv_done, 1'b0);
    chk("midrst_data_o", data_o, 32'h0);
    valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    fill_const(DEPTH, 8'sd7, 8'sd7);
    run("after_rst", 1, 1'b0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
